// File: rtl/wb_stage_if.sv
// Memory-stage -> writeback bundle plus the register-file write port and
// status outputs of the writeback stage.
interface wb_stage_if #(parameter int RF_AW = 5) ();
  logic             in_valid;
  logic [RF_AW-1:0] in_rd;
  logic             in_reg_write;
  logic             in_mem_to_reg;
  logic [18:0]      in_alu_result;
  logic [18:0]      in_read_data;
  logic             fft_key;
  logic             crypto_key;
  logic             fft_done;
  logic             crypto_done;
  logic             flush;
  logic             stall;
  logic             rf_we;
  logic [RF_AW-1:0] rf_waddr;
  logic [18:0]      rf_wdata;
  logic             acc_err;

  modport master (
    output in_valid, in_rd, in_reg_write, in_mem_to_reg, in_alu_result,
           in_read_data, fft_key, crypto_key, fft_done, crypto_done, flush,
    input  stall, rf_we, rf_waddr, rf_wdata, acc_err
  );

  modport slave (
    input  in_valid, in_rd, in_reg_write, in_mem_to_reg, in_alu_result,
           in_read_data, fft_key, crypto_key, fft_done, crypto_done, flush,
    output stall, rf_we, rf_waddr, rf_wdata, acc_err
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: retires instructions to the register file and parks the
// pipeline on accelerator-window accesses until done or timeout.
module wb_stage #(
  parameter int TIMEOUT = 1023,
  parameter int RF_AW   = 5
) (
  input  logic       clk,
  input  logic       rst,
  wb_stage_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT_FFT, WAIT_CRY} state_t;

  localparam logic [17:0] TMO = 18'(TIMEOUT);

  state_t           state, state_n;
  logic [17:0]      cnt, cnt_n;
  logic [RF_AW-1:0] rd_q, rd_n;
  logic             rw_q, rw_n;
  logic             we_q, we_n;
  logic [RF_AW-1:0] waddr_q, waddr_n;
  logic [18:0]      wdata_q, wdata_n;
  logic             err_q, err_n;
  logic             done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      rd_q    <= rd_n;
      rw_q    <= rw_n;
      we_q    <= we_n;
      waddr_q <= waddr_n;
      wdata_q <= wdata_n;
      err_q   <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rd_n    = rd_q;
    rw_n    = rw_q;
    we_n    = 1'b0;
    waddr_n = waddr_q;
    wdata_n = wdata_q;
    err_n   = err_q;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid && !bus.flush) begin
          if (bus.fft_key || bus.crypto_key) begin
            rd_n    = bus.in_rd;
            rw_n    = bus.in_reg_write;
            cnt_n   = '0;
            state_n = bus.fft_key ? WAIT_FFT : WAIT_CRY;
          end else if (bus.in_reg_write && bus.in_rd != '0) begin
            we_n    = 1'b1;
            waddr_n = bus.in_rd;
            wdata_n = bus.in_mem_to_reg ? bus.in_read_data : bus.in_alu_result;
          end
        end
      end
      WAIT_FFT, WAIT_CRY: begin
        // only the unit we are parked on may release the stage
        done = (state == WAIT_FFT) ? bus.fft_done : bus.crypto_done;
        if (bus.flush) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (done || cnt == TMO) begin
          state_n = IDLE;
          cnt_n   = '0;
          err_n   = err_q | ~done;
          if (rw_q && rd_q != '0) begin
            we_n    = 1'b1;
            waddr_n = rd_q;
            wdata_n = {~done, cnt};
          end
        end else begin
          cnt_n = cnt + 18'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.stall    = (state != IDLE);
  assign bus.rf_we    = we_q;
  assign bus.rf_waddr = waddr_q;
  assign bus.rf_wdata = wdata_q;
  assign bus.acc_err  = err_q;

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage directly downstream of the memory stage in the 19-bit pipelined SoC. It registers each retiring instruction and drives the register-file write port, selecting either load data or the ALU/address result. Accesses that decode to an accelerator window (FFT or crypto) do not retire immediately. The stage holds the pipeline until that accelerator reports completion or a timeout expires, then writes a status word to the destination register.

## Interface
Parameters:
- TIMEOUT, 1023: maximum wait-cycle count before an accelerator access is abandoned; must be at most 2^18-1.
- RF_AW, 5: register-file address width.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  memory stage presents a retiring instruction.
- in_rd  in  RF_AW  destination register index.
- in_reg_write  in  1  instruction writes a register.
- in_mem_to_reg  in  1  1 selects in_read_data, 0 selects in_alu_result.
- in_alu_result  in  19  ALU result / effective address.
- in_read_data  in  19  data memory read data.
- fft_key  in  1  access targets FFT window (address[18:16]=3'b111).
- crypto_key  in  1  access targets crypto window (address[18:16]=3'b110).
- fft_done  in  1  FFT unit completion pulse.
- crypto_done  in  1  crypto unit completion pulse.
- flush  in  1  kill the current and pending instruction.
- stall  out  1  upstream must hold its outputs stable.
- rf_we  out  1  register-file write enable, one-cycle pulse per write.
- rf_waddr  out  RF_AW  write address.
- rf_wdata  out  19  write data.
- acc_err  out  1  sticky flag, set by any accelerator timeout.

## Operation
- States: IDLE, WAIT_FFT, WAIT_CRY. A 18-bit wait counter `cnt` supports the wait states.
- stall = (state != IDLE). It is combinational from the state register.
- **IDLE, in_valid=1, flush=0, fft_key=crypto_key=0 (normal retire):**
  - At the next edge, rf_we = in_reg_write & (in_rd != 0).
  - On a write, rf_waddr = in_rd and rf_wdata = in_mem_to_reg ? in_read_data : in_alu_result.
- **IDLE, in_valid=1, flush=0, fft_key|crypto_key=1 (accelerator access):**
  - Latch in_rd and in_reg_write; set cnt=0.
  - Go to WAIT_FFT if fft_key=1 (FFT has priority if both keys are high), else WAIT_CRY.
  - No write occurs on this edge.
- **WAIT_x, evaluated each edge, in priority order:**
  - flush=1: go to IDLE, no write, cnt=0.
  - Matching done=1: write {1'b0, cnt} to the latched rd, then go to IDLE.
  - cnt==TIMEOUT: write {1'b1, cnt}, set acc_err=1, then go to IDLE.
  - Otherwise: cnt = cnt+1.
- The non-matching done signal is ignored in every state.
- in_valid is ignored while not in IDLE.
- Accelerator writes are gated by the latched reg_write and by rd != 0. The wait still occurs when the write is suppressed.
- IDLE with flush=1 drops the presented instruction: no write, stays in IDLE.
- rf_waddr and rf_wdata hold their last written value while rf_we=0.
- acc_err is cleared only by rst.

## Timing
- Reset values: state=IDLE, stall=0, rf_we=0, rf_waddr=0, rf_wdata=0, cnt=0, acc_err=0.
- Normal retire latency: 1 cycle from in_valid sampled to rf_we high. Throughput is one instruction per cycle.
- Accelerator access:
  - stall rises the cycle after accept.
  - A done sampled N wait cycles after entry (first wait cycle is N=0) gives rf_we one cycle later with data N.
  - stall falls in that same cycle, so the next instruction can be accepted on the following edge.
- Timeout: rf_we and acc_err assert TIMEOUT+1 cycles after entering WAIT.
- Asynchronous rst mid-wait returns to IDLE immediately, with no write.
- A done pulse arriving while in IDLE is discarded.

## Test plan
- **Normal retire, ALU path:** in_valid=1, in_rd=3, in_reg_write=1, in_mem_to_reg=0, in_alu_result=0x12345 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=0x12345, stall=0.
- **Load path and x0 suppression:**
  - in_mem_to_reg=1, in_read_data=0x7FFFF, in_rd=5 -> wdata=0x7FFFF.
  - Same with in_rd=0 -> rf_we stays 0.
- **FFT access:** fft_key=1, in_rd=7; fft_done pulsed 4 cycles after stall rises -> stall high 5 cycles, then rf_we=1, rf_waddr=7, rf_wdata=0x00004; crypto_done pulses during the wait are ignored.
- **Timeout with TIMEOUT=8:** crypto_key=1, no crypto_done -> after 9 wait cycles rf_wdata=0x40008, acc_err=1 and stays 1 until rst.
- **Flush mid-wait:** fft_key=1, then flush and fft_done asserted on the same cycle -> IDLE, no rf_we, stall=0.
- **Async reset:** rst asserted mid-WAIT_CRY, between clock edges -> stall=0 and all outputs return to reset values immediately.
